seg7_scan_decoder: RTL and testbench



---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_glyph_decode.sv | 39 +++
 rtl/seg7_scan_decoder.sv | 161 ++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan decoder: hex glyph table (a = MSB .. g = LSB,
// active-high), alternate glyphs enabled by SEG7_DECODE_ALIAS_EN, FSM encoding, entry record.
package seg7_pkg;

   localparam logic [6:0] GLYPH_0 = 7'b1111110;
   localparam logic [6:0] GLYPH_1 = 7'b0110000;
   localparam logic [6:0] GLYPH_2 = 7'b1101101;
   localparam logic [6:0] GLYPH_3 = 7'b1111001;
   localparam logic [6:0] GLYPH_4 = 7'b0110011;
   localparam logic [6:0] GLYPH_5 = 7'b1011011;
   localparam logic [6:0] GLYPH_6 = 7'b1011111;
   localparam logic [6:0] GLYPH_7 = 7'b1110000;
   localparam logic [6:0] GLYPH_8 = 7'b1111111;
   localparam logic [6:0] GLYPH_9 = 7'b1111011;
   localparam logic [6:0] GLYPH_A = 7'b1110111;
   localparam logic [6:0] GLYPH_B = 7'b0011111;
   localparam logic [6:0] GLYPH_C = 7'b1001110;
   localparam logic [6:0] GLYPH_D = 7'b0111101;
   localparam logic [6:0] GLYPH_E = 7'b1001111;
   localparam logic [6:0] GLYPH_F = 7'b1000111;

   // Alternate renderings some display drivers use: 7 with segment f, 9 without segment d.
   localparam logic [6:0] GLYPH_ALIAS_7 = 7'b1110010;
   localparam logic [6:0] GLYPH_ALIAS_9 = 7'b1110011;

   localparam logic [1:0] ST_WAIT_STABLE = 2'd0;
   localparam logic [1:0] ST_CAPTURE     = 2'd1;
   localparam logic [1:0] ST_HOLD        = 2'd2;

   typedef struct packed {
      logic [3:0] nib;
      logic       dot;
      logic       known;
   } seg7_entry_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph matcher: active-high a..g pattern to hex nibble plus known flag.
// Alternate 7/9 glyphs are accepted only when SEG7_DECODE_ALIAS_EN is defined.
module seg7_glyph_decode
   import seg7_pkg::*;
(
   input  logic [6:0] i_pat,
   output logic [3:0] o_nib,
   output logic       o_known
);

   always_comb begin
      o_nib   = 4'h0;
      o_known = 1'b1;
      case (i_pat)
         GLYPH_0:       o_nib = 4'h0;
         GLYPH_1:       o_nib = 4'h1;
         GLYPH_2:       o_nib = 4'h2;
         GLYPH_3:       o_nib = 4'h3;
         GLYPH_4:       o_nib = 4'h4;
         GLYPH_5:       o_nib = 4'h5;
         GLYPH_6:       o_nib = 4'h6;
         GLYPH_7:       o_nib = 4'h7;
         GLYPH_8:       o_nib = 4'h8;
         GLYPH_9:       o_nib = 4'h9;
         GLYPH_A:       o_nib = 4'hA;
         GLYPH_B:       o_nib = 4'hB;
         GLYPH_C:       o_nib = 4'hC;
         GLYPH_D:       o_nib = 4'hD;
         GLYPH_E:       o_nib = 4'hE;
         GLYPH_F:       o_nib = 4'hF;
`ifdef SEG7_DECODE_ALIAS_EN
         GLYPH_ALIAS_7: o_nib = 4'h7;
         GLYPH_ALIAS_9: o_nib = 4'h9;
`endif
         default:       o_known = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reader for a scanned, active-low 7-segment display: recovers per-digit nibbles and dots
// and reports changes over valid/ready. Optional alias glyphs: SEG7_DECODE_ALIAS_EN.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int NDIGITS       = 8,
   parameter int STABLE_CYCLES = 4,
   parameter int IDX_W         = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             seg_n,
   input  logic [NDIGITS-1:0]     dig_n,
   output logic [4*NDIGITS-1:0]   digits,
   output logic [NDIGITS-1:0]     dots,
   output logic [NDIGITS-1:0]     known,
   output logic                   upd_valid,
   input  logic                   upd_ready,
   output logic [IDX_W-1:0]       upd_index,
   output logic [3:0]             upd_data,
   output logic                   upd_dot,
   output logic                   upd_known,
   output logic                   overflow
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

   logic [7:0]           r_seg_s1, r_seg_s2;
   logic [NDIGITS-1:0]   r_dig_s1, r_dig_s2;
   logic [CNT_W-1:0]     r_cnt;
   logic [1:0]           r_state;
   logic [4*NDIGITS-1:0] r_digits;
   logic [NDIGITS-1:0]   r_dots, r_known;
   logic                 r_vld, r_ovf;
   logic [IDX_W-1:0]     r_idx;
   logic [3:0]           r_data;
   logic                 r_dot, r_kn;

   logic                 w_chg, w_onehot, w_cap, w_evt;
   logic [NDIGITS-1:0]   w_sel;
   logic [IDX_W-1:0]     w_idx;
   logic [6:0]           w_pat;
   logic [3:0]           w_dec_nib;
   logic                 w_dec_known;
   seg7_entry_t          w_old, w_new;

   // A change is seen as it enters the second synchronizer stage, so the stable count
   // starts the cycle the new sample becomes visible.
   assign w_chg    = {r_dig_s1, r_seg_s1} != {r_dig_s2, r_seg_s2};
   assign w_sel    = ~r_dig_s2;
   assign w_onehot = (w_sel != '0) && ((w_sel & (w_sel - NDIGITS'(1))) == '0);
   assign w_pat    = ~r_seg_s2[6:0];

   seg7_glyph_decode u_decode (
      .i_pat   (w_pat),
      .o_nib   (w_dec_nib),
      .o_known (w_dec_known)
   );

   always_comb begin
      w_idx = '0;
      w_old = '0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (w_sel[i]) begin
            w_idx     = IDX_W'(i);
            w_old.nib = r_digits[4*i +: 4];
            w_old.dot = r_dots[i];
            w_old.known = r_known[i];
         end
      end
   end

   // Unknown patterns keep the stored nibble but still update dot and known.
   always_comb begin
      w_new.nib   = w_dec_known ? w_dec_nib : w_old.nib;
      w_new.dot   = ~r_seg_s2[7];
      w_new.known = w_dec_known;
   end

   assign w_cap = (r_state == ST_CAPTURE) && w_onehot;
   assign w_evt = w_cap && (w_new != w_old);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_seg_s1 <= '0;
         r_seg_s2 <= '0;
         r_dig_s1 <= '0;
         r_dig_s2 <= '0;
         r_cnt    <= '0;
         r_state  <= ST_WAIT_STABLE;
         r_digits <= '0;
         r_dots   <= '0;
         r_known  <= '0;
         r_vld    <= 1'b0;
         r_ovf    <= 1'b0;
         r_idx    <= '0;
         r_data   <= '0;
         r_dot    <= 1'b0;
         r_kn     <= 1'b0;
      end else begin
         r_seg_s1 <= seg_n;
         r_seg_s2 <= r_seg_s1;
         r_dig_s1 <= dig_n;
         r_dig_s2 <= r_dig_s1;

         if (w_chg)
            r_cnt <= '0;
         else if (r_cnt != CNT_W'(STABLE_CYCLES))
            r_cnt <= r_cnt + CNT_W'(1);

         case (r_state)
            ST_WAIT_STABLE:
               if (!w_chg && (r_cnt == CNT_W'(STABLE_CYCLES - 1)))
                  r_state <= ST_CAPTURE;
            ST_CAPTURE:
               r_state <= w_chg ? ST_WAIT_STABLE : ST_HOLD;
            ST_HOLD:
               if (w_chg)
                  r_state <= ST_WAIT_STABLE;
            default:
               r_state <= ST_WAIT_STABLE;
         endcase

         if (w_cap) begin
            for (int i = 0; i < NDIGITS; i++) begin
               if (w_sel[i]) begin
                  r_digits[4*i +: 4] <= w_new.nib;
                  r_dots[i]          <= w_new.dot;
                  r_known[i]         <= w_new.known;
               end
            end
         end

         // One-deep event slot; a new event may replace one leaving in the same cycle.
         if (w_evt) begin
            if (!r_vld || upd_ready) begin
               r_vld  <= 1'b1;
               r_idx  <= w_idx;
               r_data <= w_new.nib;
               r_dot  <= w_new.dot;
               r_kn   <= w_new.known;
            end else begin
               r_ovf <= 1'b1;
            end
         end else if (r_vld && upd_ready) begin
            r_vld <= 1'b0;
         end
      end
   end

   assign digits    = r_digits;
   assign dots      = r_dots;
   assign known     = r_known;
   assign upd_valid = r_vld;
   assign upd_index = r_idx;
   assign upd_data  = r_data;
   assign upd_dot   = r_dot;
   assign upd_known = r_kn;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: hand-computed register file contents and event stream.
module tb_seg7_scan_decoder;
   import seg7_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  seg_n;
   logic [7:0]  dig_n;
   logic [31:0] digits;
   logic [7:0]  dots, known;
   logic        upd_valid, upd_ready;
   logic [2:0]  upd_index;
   logic [3:0]  upd_data;
   logic        upd_dot, upd_known, overflow;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [8:0]  ev_q[$];

   always #5 clk = ~clk;

   seg7_scan_decoder #(.NDIGITS(8), .STABLE_CYCLES(4), .IDX_W(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .seg_n     (seg_n),
      .dig_n     (dig_n),
      .digits    (digits),
      .dots      (dots),
      .known     (known),
      .upd_valid (upd_valid),
      .upd_ready (upd_ready),
      .upd_index (upd_index),
      .upd_data  (upd_data),
      .upd_dot   (upd_dot),
      .upd_known (upd_known),
      .overflow  (overflow)
   );

   // Record every accepted event: {known, dot, data, index}.
   always @(negedge clk) begin
      if (reset === 1'b0 && upd_valid === 1'b1 && upd_ready === 1'b1)
         ev_q.push_back({upd_known, upd_dot, upd_data, upd_index});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic expect_event(input string tag, input logic [2:0] idx, input logic [3:0] data,
                               input logic dot, input logic kn);
      logic [8:0] e;
      check({tag, "_present"}, 32'(ev_q.size() != 0), 1);
      if (ev_q.size() != 0) begin
         e = ev_q.pop_front();
         check(tag, 32'(e), 32'({kn, dot, data, idx}));
      end
   endtask

   initial begin
      reset     = 1'b1;
      dig_n     = 8'hFF;
      seg_n     = 8'hFF;
      upd_ready = 1'b1;
      tick(3);
      check("rst_digits", digits, 0);
      check("rst_dots", 32'(dots), 0);
      check("rst_known", 32'(known), 0);
      check("rst_valid", 32'(upd_valid), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_state", 32'(dut.r_state), 32'(ST_WAIT_STABLE));
      reset = 1'b0;
      tick(12);
      check("idle_no_event", 32'(ev_q.size()), 0);

      // Digit 0 shows 3, no dot; capture lands on the 7th edge.
      dig_n = 8'hFE;
      seg_n = 8'h86;
      tick(6);
      check("lat_early_known", 32'(known[0]), 0);
      check("lat_early_valid", 32'(upd_valid), 0);
      tick(1);
      check("d0_nib", 32'(digits[3:0]), 3);
      check("d0_dot", 32'(dots[0]), 0);
      check("d0_known", 32'(known[0]), 1);
      check("ev1_valid", 32'(upd_valid), 1);
      check("ev1_fields", 32'({upd_known, upd_dot, upd_data, upd_index}), 32'({1'b1, 1'b0, 4'h3, 3'd0}));
      tick(3);
      expect_event("ev1", 3'd0, 4'h3, 1'b0, 1'b1);
      check("ev1_drained", 32'(upd_valid), 0);

      // Same digit gains its dot, then holds without new events.
      seg_n = 8'h06;
      tick(7);
      check("d0_dot_set", 32'(dots[0]), 1);
      check("ev2_fields", 32'({upd_known, upd_dot, upd_data, upd_index}), 32'({1'b1, 1'b1, 4'h3, 3'd0}));
      tick(50);
      expect_event("ev2", 3'd0, 4'h3, 1'b1, 1'b1);
      check("hold_no_more", 32'(ev_q.size()), 0);

      // Consumer stalled: second event is dropped but the register file still updates.
      upd_ready = 1'b0;
      dig_n = 8'hFB;
      seg_n = 8'h88;
      tick(10);
      check("stall_valid", 32'(upd_valid), 1);
      check("stall_fields", 32'({upd_known, upd_dot, upd_data, upd_index}), 32'({1'b1, 1'b0, 4'hA, 3'd2}));
      dig_n = 8'hF7;
      seg_n = 8'hCF;
      tick(10);
      check("d2_nib", 32'(digits[11:8]), 32'hA);
      check("d3_nib", 32'(digits[15:12]), 1);
      check("d3_known", 32'(known[3]), 1);
      check("ovf_set", 32'(overflow), 1);
      check("held_fields", 32'({upd_known, upd_dot, upd_data, upd_index}), 32'({1'b1, 1'b0, 4'hA, 3'd2}));
      check("stall_no_xfer", 32'(ev_q.size()), 0);
      upd_ready = 1'b1;
      tick(2);
      expect_event("ev3", 3'd2, 4'hA, 1'b0, 1'b1);
      check("after_drop_empty", 32'(ev_q.size()), 0);
      check("ovf_sticky", 32'(overflow), 1);

      // Glitch: a 5 shown too briefly on digit 0 must not be captured.
      dig_n = 8'hFE;
      seg_n = 8'hA4;
      tick(4);
      seg_n = 8'h06;
      tick(12);
      check("glitch_nib", 32'(digits[3:0]), 3);
      check("glitch_dot", 32'(dots[0]), 1);
      check("glitch_no_event", 32'(ev_q.size()), 0);

      // Two digits selected at once: ignored.
      dig_n = 8'hFC;
      seg_n = 8'hA4;
      tick(12);
      check("multi_d1_nib", 32'(digits[7:4]), 0);
      check("multi_d1_known", 32'(known[1]), 0);
      check("multi_d0_nib", 32'(digits[3:0]), 3);
      check("multi_no_event", 32'(ev_q.size()), 0);

      // Blank keeps the nibble but clears known.
      dig_n = 8'hFE;
      seg_n = 8'hFF;
      tick(10);
      check("blank_known", 32'(known[0]), 0);
      check("blank_nib", 32'(digits[3:0]), 3);
      check("blank_dot", 32'(dots[0]), 0);
      expect_event("ev_blank", 3'd0, 4'h3, 1'b0, 1'b0);

      // Seven drawn with segment f.
      seg_n = 8'h8D;
      tick(10);
`ifdef SEG7_DECODE_ALIAS_EN
      check("alias7_nib", 32'(digits[3:0]), 7);
      check("alias7_known", 32'(known[0]), 1);
      expect_event("ev_alias7", 3'd0, 4'h7, 1'b0, 1'b1);
`else
      check("alias7_nib", 32'(digits[3:0]), 3);
      check("alias7_known", 32'(known[0]), 0);
      check("alias7_no_event", 32'(ev_q.size()), 0);
`endif

      // Reset while holding a stable pattern.
      reset = 1'b1;
      seg_n = 8'h86;
      tick(1);
      check("mid_rst_digits", digits, 0);
      check("mid_rst_known", 32'(known), 0);
      check("mid_rst_dots", 32'(dots), 0);
      check("mid_rst_outs", 32'({upd_valid, upd_index, upd_data, upd_dot, upd_known, overflow}), 0);
      check("mid_rst_state", 32'(dut.r_state), 32'(ST_WAIT_STABLE));
      reset = 1'b0;
      tick(10);
      check("post_rst_nib", 32'(digits[3:0]), 3);
      expect_event("ev_post_rst", 3'd0, 4'h3, 1'b0, 1'b1);
      check("post_rst_ovf", 32'(overflow), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
